// File: rtl/dec_pipeline.sv
// dec_pipeline: three-stage 16-bit decryption pipeline (byte unswap, key rotate-right, key un-XOR)
// with valid/ready flow control on both ends. Optional define DEC_BYPASS_EN adds a per-word bypass input.

module dec_pipeline #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [5:0]        key_bits,
`ifdef DEC_BYPASS_EN
    input  logic              bypass,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  word_count
);

    function automatic logic [15:0] d1_unswap(input logic [15:0] d);
        return {d[7:0], d[15:8]};
    endfunction

    // Rotation amount is 1..4; the field is widened before the +1 so 3 maps to 4.
    function automatic logic [15:0] d2_unrotate(input logic [15:0] d, input logic [1:0] k);
        logic [2:0]  amt;
        logic [31:0] dbl;
        amt = {1'b0, k} + 3'd1;
        dbl = {d, d} >> amt;
        return dbl[15:0];
    endfunction

    function automatic logic [15:0] d3_unxor(input logic [15:0] d, input logic [5:0] k);
        logic [15:0] m;
        m = {k[0], {5{k[2:0]}}};
        return k[5] ? ~(d ^ m) : (d ^ m);
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q,  s1_data_d;
    logic [5:0]        s1_key_q,   s1_key_d;
    logic              s1_byp_q,   s1_byp_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q,  s2_data_d;
    logic [5:0]        s2_key_q,   s2_key_d;
    logic              s2_byp_q,   s2_byp_d;
    logic              s3_valid_q, s3_valid_d;
    logic [DATA_W-1:0] s3_data_q,  s3_data_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;

    logic in_byp;
    logic s1_take, s2_take, s3_take;
    logic in_fire, out_fire;

`ifdef DEC_BYPASS_EN
    assign in_byp = bypass;
`else
    assign in_byp = 1'b0;
`endif

    // Ready chain runs combinationally from out_ready so a full pipe advances as a whole.
    always_comb begin
        s3_take  = !s3_valid_q || out_ready;
        s2_take  = !s2_valid_q || s3_take;
        s1_take  = !s1_valid_q || s2_take;
        in_fire  = in_valid && s1_take;
        out_fire = s3_valid_q && out_ready;
    end

    assign in_ready   = s1_take;
    assign out_valid  = s3_valid_q;
    assign out_data   = s3_data_q;
    assign word_count = word_count_q;

    // Next-state for every stage: transform on transfer, otherwise hold.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        s1_key_d     = s1_key_q;
        s1_byp_d     = s1_byp_q;
        s2_valid_d   = s2_valid_q;
        s2_data_d    = s2_data_q;
        s2_key_d     = s2_key_q;
        s2_byp_d     = s2_byp_q;
        s3_valid_d   = s3_valid_q;
        s3_data_d    = s3_data_q;
        word_count_d = word_count_q;

        if (s1_take) begin
            s1_valid_d = in_fire;
            if (in_fire) begin
                s1_data_d = in_byp ? in_data : d1_unswap(in_data);
                s1_key_d  = key_bits;
                s1_byp_d  = in_byp;
            end else begin
                s1_data_d = s1_data_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_take) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = s1_byp_q ? s1_data_q : d2_unrotate(s1_data_q, s1_key_q[4:3]);
                s2_key_d  = s1_key_q;
                s2_byp_d  = s1_byp_q;
            end else begin
                s2_data_d = s2_data_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end

        if (s3_take) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_data_d = s2_byp_q ? s2_data_q : d3_unxor(s2_data_q, s2_key_q);
            end else begin
                s3_data_d = s3_data_q;
            end
        end else begin
            s3_valid_d = s3_valid_q;
        end

        if (out_fire) begin
            word_count_d = word_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            word_count_d = word_count_q;
        end
    end

    // State registers with synchronous reset that also flushes in-flight words.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_key_q     <= 6'd0;
            s1_byp_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_key_q     <= 6'd0;
            s2_byp_q     <= 1'b0;
            s3_valid_q   <= 1'b0;
            s3_data_q    <= '0;
            word_count_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_key_q     <= s1_key_d;
            s1_byp_q     <= s1_byp_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_key_q     <= s2_key_d;
            s2_byp_q     <= s2_byp_d;
            s3_valid_q   <= s3_valid_d;
            s3_data_q    <= s3_data_d;
            word_count_q <= word_count_d;
        end
    end

endmodule

// File: tb/tb_dec_pipeline.sv
// Self-checking bench for dec_pipeline: directed vector table, multi-cycle corner sequences,
// and randomized traffic scored against a behavioural decryption model.

module tb_dec_pipeline;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [5:0]  key_bits;
    logic        tb_bypass;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] word_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dec_pipeline #(.DATA_W(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .key_bits   (key_bits),
`ifdef DEC_BYPASS_EN
        .bypass     (tb_bypass),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .word_count (word_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: undo byte permutation, rotation and key XOR with plain arithmetic.
    function automatic logic [15:0] ref_dec(input logic [15:0] c, input logic [5:0] k, input logic byp);
        logic [15:0] x;
        logic [15:0] m;
        logic [31:0] w;
        int          n;
        if (byp) return c;
        x = {c[7:0], c[15:8]};
        n = int'(k[4:3]) + 1;
        w = {16'h0000, x};
        w = (w >> n) | (w << (16 - n));
        x = w[15:0];
        for (int i = 0; i < 15; i++) m[i] = k[i % 3];
        m[15] = k[0];
        x = x ^ m;
        if (k[5]) x = ~x;
        return x;
    endfunction

    // Scoreboard / protocol monitor, sampled on the falling edge.
    logic [15:0] exp_q[$];
    logic [15:0] m_count;
    logic        hold_pending;
    logic [15:0] hold_data;
    logic        mon_en = 1'b0;
    logic        cur_byp;
    logic [15:0] sb_exp;

    always @(negedge clk) begin
        if (mon_en) begin
            check("wc_model", 32'(word_count), 32'(m_count));
            if (hold_pending) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_data));
            end
            if (rst) begin
                exp_q.delete();
                m_count      = 16'd0;
                hold_pending = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        sb_exp = exp_q.pop_front();
                        check("sb_data", 32'(out_data), 32'(sb_exp));
                    end
                    m_count = m_count + 16'd1;
                end
                hold_pending = out_valid && !out_ready;
                hold_data    = out_data;
`ifdef DEC_BYPASS_EN
                cur_byp = tb_bypass;
`else
                cur_byp = 1'b0;
`endif
                if (in_valid && in_ready) exp_q.push_back(ref_dec(in_data, key_bits, cur_byp));
            end
        end
    end

    typedef struct {
        logic [15:0] din;
        logic [5:0]  key;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int          lat;
        bit          found;
        int          first_v, last_v, nvalid, accepted;
        bit          need_new;
        logic [15:0] wc0, held;
        logic [15:0] got[$];

        vecs[0] = '{16'h1234, 6'b001010, 16'hA996};
        vecs[1] = '{16'h1234, 6'b101010, 16'h5669};
        vecs[2] = '{16'h0000, 6'b000000, 16'h0000};
        vecs[3] = '{16'h0000, 6'b100000, 16'hFFFF};
        vecs[4] = '{16'h0000, 6'b000111, 16'hFFFF};
        vecs[5] = '{16'hFFFF, 6'b000111, 16'h0000};
        vecs[6] = '{16'h0001, 6'b011000, 16'h0010};
        vecs[7] = '{16'h0001, 6'b000001, 16'h92C9};
        vecs[8] = '{16'h0100, 6'b000000, 16'h8000};

        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; key_bits = 6'd0;
        tb_bypass = 1'b0; out_ready = 1'b1;
        m_count = 16'd0; hold_pending = 1'b0; hold_data = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Directed vectors, one isolated word at a time.
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = vecs[i].din; key_bits = vecs[i].key;
            @(negedge clk);
            check("tbl_in_ready", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            lat = 1; found = 1'b0;
            while (!found && lat <= 6) begin
                @(negedge clk);
                if (out_valid) found = 1'b1;
                else begin
                    tick();
                    lat++;
                end
            end
            check("tbl_latency", 32'(lat), 32'd3);
            check("tbl_data", 32'(out_data), 32'(vecs[i].exp));
            tick();
            if (i == 0) begin
                @(negedge clk);
                check("wc_after_first", 32'(word_count), 32'd1);
                tick();
            end
        end

        // Back-to-back stream of 8 words with distinct keys.
        reset_dut();
        first_v = -1; last_v = -1; nvalid = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 8);
            if (c < 8) begin
                in_data  = 16'($urandom);
                key_bits = 6'(c * 9);
            end
            @(negedge clk);
            if (c < 8) check("b2b_in_ready", 32'(in_ready), 32'd1);
            if (out_valid) begin
                nvalid++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            tick();
        end
        check("b2b_count", 32'(nvalid), 32'd8);
        check("b2b_contiguous", 32'(last_v - first_v), 32'd7);
        check("b2b_word_count", 32'(word_count), 32'd8);

        // Backpressure: five words offered against a stalled output.
        wc0 = word_count;
        out_ready = 1'b0; accepted = 0; need_new = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (need_new) begin
                in_data = 16'($urandom); key_bits = 6'($urandom); need_new = 1'b0;
            end
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                accepted++;
                need_new = 1'b1;
            end
            tick();
        end
        check("bp_accepted", 32'(accepted), 32'd3);
        @(negedge clk);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        held = out_data;
        tick(); tick();
        @(negedge clk);
        check("bp_stable", 32'(out_data), 32'(held));
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 10 && accepted < 5; c++) begin
            if (need_new) begin
                in_data = 16'($urandom); key_bits = 6'($urandom); need_new = 1'b0;
            end
            in_valid = 1'b1;
            @(negedge clk);
            if (c == 0) check("bp_release_in_ready", 32'(in_ready), 32'd1);
            if (in_ready) begin
                accepted++;
                need_new = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        check("bp_drained", 32'(word_count - wc0), 32'd5);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            key_bits  = 6'($urandom);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        // Reset with three words in flight.
        out_ready = 1'b0; accepted = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_data = 16'($urandom); key_bits = 6'($urandom);
            @(negedge clk);
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        check("flush_loaded", 32'(accepted), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_word_count", 32'(word_count), 32'd0);
        out_ready = 1'b1; nvalid = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) nvalid++;
            tick();
        end
        check("flush_no_output", 32'(nvalid), 32'd0);

`ifdef DEC_BYPASS_EN
        // Bypass word between two normally decoded neighbours.
        for (int c = 0; c < 12; c++) begin
            in_valid  = (c < 3);
            tb_bypass = (c == 1);
            in_data   = (c == 1) ? 16'hBEEF : 16'h1234;
            key_bits  = (c == 1) ? 6'($urandom) : 6'b001010;
            @(negedge clk);
            if (out_valid) got.push_back(out_data);
            tick();
        end
        tb_bypass = 1'b0;
        check("byp_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("byp_first", 32'(got[0]), 32'hA996);
            check("byp_word", 32'(got[1]), 32'hBEEF);
            check("byp_third", 32'(got[2]), 32'hA996);
        end
`endif

        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
